bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces the four digit nibbles consumed by the 4-digit seven-segment multiplexed display driver; sits between the Wishbone register file and that driver.
- Start/busy/done handshake; digit outputs hold the last result steadily so the display never shows partial values.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 tb/tb_bin2bcd_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int DEF_BIN_W   = 14;
   localparam int DEF_DIGITS  = 4;
   localparam int DEF_MAX_VAL = 9999;
   localparam int NIB_W       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before it is doubled.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [NIB_W-1:0] nib,
   output logic [NIB_W-1:0] corr
);

   assign corr = (nib >= NIB_W'(5)) ? nib + NIB_W'(3) : nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, with saturation to MAX_VAL and
// digit outputs that only change when a conversion completes.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W   = DEF_BIN_W,
   parameter int DIGITS  = DEF_DIGITS,
   parameter int MAX_VAL = DEF_MAX_VAL
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic             overflow,
   output logic [NIB_W-1:0] dig3,
   output logic [NIB_W-1:0] dig2,
   output logic [NIB_W-1:0] dig1,
   output logic [NIB_W-1:0] dig0
);

   localparam int BCD_W = DIGITS * NIB_W;
   localparam int CNT_W = $clog2(BIN_W);

   state_t                   state;
   logic [BCD_W-1:0]         bcd;
   logic [BCD_W-1:0]         bcd_corr;
   logic [BCD_W-1:0]         dig_q;
   logic [BIN_W-1:0]         bin_reg;
   logic [CNT_W-1:0]         cnt;
   logic                     ovf_pend;
   logic [BCD_W+BIN_W-1:0]   shift_next;

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .nib  (bcd[i*NIB_W +: NIB_W]),
         .corr (bcd_corr[i*NIB_W +: NIB_W])
      );
   end

   // Saturation keeps the thousands digit below 10, so the bit shifted out the top is always 0.
   assign shift_next = {bcd_corr, bin_reg} << 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         dig_q    <= '0;
         bcd      <= '0;
         bin_reg  <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let the default below be overridden later in the
         // same block while every register still samples pre-edge values.
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  if (bin > BIN_W'(MAX_VAL)) begin
                     bin_reg  <= BIN_W'(MAX_VAL);
                     ovf_pend <= 1'b1;
                  end else begin
                     bin_reg  <= bin;
                     ovf_pend <= 1'b0;
                  end
                  bcd   <= '0;
                  cnt   <= CNT_W'(BIN_W - 1);
                  busy  <= 1'b1;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            SHIFT: begin
               bcd     <= shift_next[BCD_W+BIN_W-1 -: BCD_W];
               bin_reg <= shift_next[BIN_W-1:0];
               cnt     <= cnt - CNT_W'(1);
               if (cnt == '0) begin
                  dig_q    <= shift_next[BCD_W+BIN_W-1 -: BCD_W];
                  overflow <= ovf_pend;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dig3 = dig_q[3*NIB_W +: NIB_W];
   assign dig2 = dig_q[2*NIB_W +: NIB_W];
   assign dig1 = dig_q[1*NIB_W +: NIB_W];
   assign dig0 = dig_q[0*NIB_W +: NIB_W];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: stimulus pushes hand-computed BCD results, a negedge
// monitor pops and compares on every done pulse and checks the digits hold in between.
module tb_bin2bcd_seq;

   typedef struct packed {
      logic [15:0] d;
      logic        o;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [13:0] bin = '0;
   logic        busy, done, overflow;
   logic [3:0]  dig3, dig2, dig1, dig0;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   exp_t sb[$];
   exp_t held = '0;

   bin2bcd_seq dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bin      (bin),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .dig3     (dig3),
      .dig2     (dig2),
      .dig1     (dig1),
      .dig0     (dig0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares on done, and checks outputs hold the last result otherwise.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               held = sb.pop_front();
               check("digits", {dig3, dig2, dig1, dig0}, held.d);
               check("overflow", overflow, held.o);
            end
         end else begin
            check("hold_digits", {dig3, dig2, dig1, dig0}, held.d);
            check("hold_overflow", overflow, held.o);
         end
      end
   end

   task automatic issue(input logic [13:0] b, input logic [15:0] ed, input logic eo,
                        input bit hold);
      exp_t e;
      e.d = ed;
      e.o = eo;
      start = 1'b1;
      bin   = b;
      sb.push_back(e);
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Called at the negedge after the accepting edge; returns at the done negedge.
   task automatic wait_done(input int mode, input logic [13:0] keep, output int done_at);
      int n  = 0;
      int nb = 0;
      bit seen = 0;
      while (!seen && n < 40) begin
         if (done) begin
            seen = 1;
         end else begin
            if (busy) nb++;
            n++;
            if (mode == 1 && n == 3) bin = 14'd7777;
            if (mode == 1 && n == 7) bin = keep;
            if (mode == 2 && n == 5) begin start = 1'b1; bin = 14'd8888; end
            if (mode == 2 && n == 6) begin start = 1'b0; bin = keep; end
            @(negedge clk);
         end
      end
      check("done_seen", 32'(seen), 32'd1);
      check("latency", n, 32'd14);
      check("busy_cycles", nb, 32'd14);
      done_at = cyc;
   endtask

   task automatic conv(input logic [13:0] b, input logic [15:0] ed, input logic eo,
                       input int mode);
      int t;
      @(negedge clk);
      issue(b, ed, eo, 1'b0);
      wait_done(mode, b, t);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d1, d2, d3;

      #1;
      check("reset_digits", {dig3, dig2, dig1, dig0}, 32'h0);
      check("reset_busy", busy, 32'd0);
      check("reset_done", done, 32'd0);
      check("reset_overflow", overflow, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      conv(14'd0,     16'h0000, 1'b0, 0);
      conv(14'd1234,  16'h1234, 1'b0, 0);
      conv(14'd9999,  16'h9999, 1'b0, 0);
      conv(14'd10,    16'h0010, 1'b0, 0);
      conv(14'd10000, 16'h9999, 1'b1, 0);
      conv(14'd16383, 16'h9999, 1'b1, 0);
      conv(14'd5,     16'h0005, 1'b0, 0);

      // start pulse and bin change mid-conversion must be ignored
      conv(14'd2468,  16'h2468, 1'b0, 2);
      repeat (20) @(negedge clk);
      check("no_queued_start", sb.size(), 32'd0);

      // start held high: done every BIN_W+1 cycles, bin wiggles while busy
      @(negedge clk);
      issue(14'd4321, 16'h4321, 1'b0, 1'b1);
      wait_done(1, 14'd4321, d1);
      issue(14'd4321, 16'h4321, 1'b0, 1'b1);
      wait_done(1, 14'd4321, d2);
      issue(14'd4321, 16'h4321, 1'b0, 1'b1);
      wait_done(1, 14'd4321, d3);
      start = 1'b0;
      check("period_1", d2 - d1, 32'd15);
      check("period_2", d3 - d2, 32'd15);
      repeat (20) @(negedge clk);
      check("idle_after_hold", busy, 32'd0);

      // back-to-back: start during the done cycle
      conv(14'd1234, 16'h1234, 1'b0, 0);
      issue(14'd42, 16'h0042, 1'b0, 1'b0);
      wait_done(0, 14'd42, d1);

      // async reset in the middle of a conversion
      @(negedge clk);
      issue(14'd5678, 16'h5678, 1'b0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      held = '0;
      #1;
      check("midreset_digits", {dig3, dig2, dig1, dig0}, 32'h0);
      check("midreset_busy", busy, 32'd0);
      check("midreset_done", done, 32'd0);
      check("midreset_overflow", overflow, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("idle_after_reset", busy, 32'd0);
      conv(14'd5678, 16'h5678, 1'b0, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
